// File: rtl/spi_peripheral_sync.sv
// SPI peripheral running entirely on m_clk: pad inputs are synchronized and SCK edges
// are detected by oversampling, so SCK must stay at or below m_clk/8.
module spi_peripheral_sync #(
    parameter int unsigned WORD_W      = 8,
    parameter bit          CPOL        = 1'b0,
    parameter bit          CPHA        = 1'b0,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic              m_clk,
    input  logic              rst,
    input  logic              sck_pad,
    input  logic              csn_pad,
    input  logic              mosi_pad,
    output logic              miso_pad,
    output logic [WORD_W-1:0] rx_data,
    output logic              rx_valid,
    input  logic              rx_ready,
    input  logic [WORD_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              busy,
    output logic              rx_overrun,
    output logic              tx_underrun
);

    localparam int unsigned    CNT_W    = $clog2(WORD_W);
    localparam logic [CNT_W-1:0] LAST   = CNT_W'(WORD_W - 1);
    localparam logic [1:0]     SETTLE   = 2'(SYNC_STAGES);
    localparam logic [2:0]     SYNC_RST = {1'b0, 1'b1, CPOL};   // {mosi, csn, sck}

    // Synchronizer chain, one 3-bit slice per stage
    logic [SYNC_STAGES-1:0][2:0] sync_reg;
    logic [SYNC_STAGES-1:0][2:0] sync_in;

    generate
        for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
            if (gi == 0) begin : g_first
                assign sync_in[gi] = {mosi_pad, csn_pad, sck_pad};
            end else begin : g_chain
                assign sync_in[gi] = sync_reg[gi-1];
            end
        end
    endgenerate

    always_ff @(posedge m_clk) begin
        if (rst) sync_reg <= {SYNC_STAGES{SYNC_RST}};
        else     sync_reg <= sync_in;
    end

    logic sck_s, csn_s, mosi_s;
    assign sck_s  = sync_reg[SYNC_STAGES-1][0];
    assign csn_s  = sync_reg[SYNC_STAGES-1][1];
    assign mosi_s = sync_reg[SYNC_STAGES-1][2];

    logic              sck_d_reg, csn_d_reg;
    logic [1:0]        settle_cnt_reg;
    logic              armed_reg;
    logic [CNT_W-1:0]  bit_cnt_reg;
    logic [WORD_W-2:0] rx_shift_reg;
    logic [WORD_W-1:0] rx_data_reg;
    logic              rx_valid_reg, rx_overrun_reg;
    logic [WORD_W-1:0] hold_reg, tx_shift_reg;
    logic              hold_full_reg, load_pending_reg, hold_first_reg, tx_underrun_reg;

    logic active, csn_fall, lead, trail, sample, launch, wrap, tx_load, accept;

    // armed_reg only rises once the flushed synchronizer shows csn high, so a csn held
    // low across reset never produces a false word start.
    assign active   = armed_reg & ~csn_s;
    assign csn_fall = armed_reg & csn_d_reg & ~csn_s;
    assign lead     = active & (sck_s != CPOL) & (sck_d_reg == CPOL);
    assign trail    = active & (sck_s == CPOL) & (sck_d_reg != CPOL);
    assign sample   = CPHA ? trail : lead;
    assign launch   = CPHA ? lead : trail;
    assign wrap     = sample & (bit_cnt_reg == LAST);
    // A wrap only arms the reload; it takes effect on the next launch edge, which is
    // where the following word's MSB must appear. A word that is never clocked
    // therefore never consumes the holding register or reports an underrun.
    assign tx_load  = csn_fall | (launch & load_pending_reg);
    assign accept   = tx_valid & ~hold_full_reg;

    always_ff @(posedge m_clk) begin
        if (rst) begin
            sck_d_reg        <= CPOL;
            csn_d_reg        <= 1'b1;
            settle_cnt_reg   <= '0;
            armed_reg        <= 1'b0;
            bit_cnt_reg      <= '0;
            rx_shift_reg     <= '0;
            rx_data_reg      <= '0;
            rx_valid_reg     <= 1'b0;
            rx_overrun_reg   <= 1'b0;
            hold_reg         <= '0;
            hold_full_reg    <= 1'b0;
            tx_shift_reg     <= '0;
            load_pending_reg <= 1'b0;
            hold_first_reg   <= 1'b0;
            tx_underrun_reg  <= 1'b0;
        end else begin
            sck_d_reg       <= sck_s;
            csn_d_reg       <= csn_s;
            rx_overrun_reg  <= 1'b0;
            tx_underrun_reg <= 1'b0;

            if (settle_cnt_reg != SETTLE) settle_cnt_reg <= settle_cnt_reg + 1'b1;
            else if (csn_s)                armed_reg      <= 1'b1;

            if (!active) begin
                bit_cnt_reg      <= '0;
                rx_shift_reg     <= '0;
                tx_shift_reg     <= '0;
                load_pending_reg <= 1'b0;
                hold_first_reg   <= 1'b0;
            end else begin
                if (sample) begin
                    rx_shift_reg <= {rx_shift_reg[WORD_W-3:0], mosi_s};
                    bit_cnt_reg  <= wrap ? '0 : bit_cnt_reg + 1'b1;
                    if (wrap) load_pending_reg <= 1'b1;
                end
                if (tx_load) begin
                    tx_shift_reg     <= hold_full_reg ? hold_reg : '0;
                    tx_underrun_reg  <= ~hold_full_reg;
                    load_pending_reg <= 1'b0;
                    // With CPHA=1 the first leading edge of a framed word keeps the MSB
                    hold_first_reg   <= CPHA & csn_fall;
                end else if (launch) begin
                    if (hold_first_reg) hold_first_reg <= 1'b0;
                    else                tx_shift_reg   <= tx_shift_reg << 1;
                end
            end

            if (wrap) begin
                rx_data_reg    <= {rx_shift_reg, mosi_s};
                rx_valid_reg   <= 1'b1;
                rx_overrun_reg <= rx_valid_reg & ~rx_ready;
            end else if (rx_valid_reg && rx_ready) begin
                rx_valid_reg <= 1'b0;
            end

            // A word offered in the same cycle as a load lands after the load empties the register
            if (tx_load) hold_full_reg <= 1'b0;
            if (accept) begin
                hold_reg      <= tx_data;
                hold_full_reg <= 1'b1;
            end
        end
    end

    assign miso_pad    = active & tx_shift_reg[WORD_W-1];
    assign rx_data     = rx_data_reg;
    assign rx_valid    = rx_valid_reg;
    assign tx_ready    = ~hold_full_reg;
    assign busy        = active;
    assign rx_overrun  = rx_overrun_reg;
    assign tx_underrun = tx_underrun_reg;

endmodule

// File: tb/tb_spi_peripheral_sync.sv
// Bench for spi_peripheral_sync: an 8-bit mode-0 instance and a 16-bit mode-3 instance,
// driven by a bit-level SPI controller model with a scoreboard on received words.
module tb_spi_peripheral_sync;

    logic m_clk = 1'b0;
    logic rst   = 1'b1;
    always #5 m_clk = ~m_clk;

    // Mode-0, 8-bit instance
    logic       a_sck = 1'b0, a_csn = 1'b1, a_mosi = 1'b0, a_miso;
    logic [7:0] a_rx_data, a_tx_data = 8'h00;
    logic       a_rx_valid, a_rx_ready = 1'b1, a_tx_valid = 1'b0, a_tx_ready;
    logic       a_busy, a_ovr, a_und;

    // Mode-3, 16-bit instance
    logic        b_sck = 1'b1, b_csn = 1'b1, b_mosi = 1'b0, b_miso;
    logic [15:0] b_rx_data, b_tx_data = 16'h0000;
    logic        b_rx_valid, b_rx_ready = 1'b1, b_tx_valid = 1'b0, b_tx_ready;
    logic        b_busy, b_ovr, b_und;

    spi_peripheral_sync #(.WORD_W(8), .CPOL(1'b0), .CPHA(1'b0), .SYNC_STAGES(2)) u_m0 (
        .m_clk(m_clk), .rst(rst), .sck_pad(a_sck), .csn_pad(a_csn), .mosi_pad(a_mosi),
        .miso_pad(a_miso), .rx_data(a_rx_data), .rx_valid(a_rx_valid), .rx_ready(a_rx_ready),
        .tx_data(a_tx_data), .tx_valid(a_tx_valid), .tx_ready(a_tx_ready), .busy(a_busy),
        .rx_overrun(a_ovr), .tx_underrun(a_und));

    spi_peripheral_sync #(.WORD_W(16), .CPOL(1'b1), .CPHA(1'b1), .SYNC_STAGES(2)) u_m3 (
        .m_clk(m_clk), .rst(rst), .sck_pad(b_sck), .csn_pad(b_csn), .mosi_pad(b_mosi),
        .miso_pad(b_miso), .rx_data(b_rx_data), .rx_valid(b_rx_valid), .rx_ready(b_rx_ready),
        .tx_data(b_tx_data), .tx_valid(b_tx_valid), .tx_ready(b_tx_ready), .busy(b_busy),
        .rx_overrun(b_ovr), .tx_underrun(b_und));

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    // Scoreboards: expected received words, popped when the consumer handshake happens
    logic [7:0]  q0[$];
    logic [15:0] q1[$];
    int a_rx_events = 0, b_rx_events = 0, a_ovr_cnt = 0, a_und_cnt = 0, b_und_cnt = 0;
    logic a_rx_valid_prev = 1'b0, b_rx_valid_prev = 1'b0;

    always @(negedge m_clk) begin
        if (a_rx_valid && !a_rx_valid_prev) a_rx_events++;
        if (b_rx_valid && !b_rx_valid_prev) b_rx_events++;
        a_rx_valid_prev = a_rx_valid;
        b_rx_valid_prev = b_rx_valid;
        if (a_ovr) a_ovr_cnt++;
        if (a_und) a_und_cnt++;
        if (b_und) b_und_cnt++;
        if (a_rx_valid && a_rx_ready && !rst) begin
            if (q0.size() == 0) begin
                checks++; errors++;
                $display("FAIL rx0_unexpected: got word %0h, expected none", a_rx_data);
            end else check("rx0_word", 32'(a_rx_data), 32'(q0.pop_front()));
        end
        if (b_rx_valid && b_rx_ready && !rst) begin
            if (q1.size() == 0) begin
                checks++; errors++;
                $display("FAIL rx1_unexpected: got word %0h, expected none", b_rx_data);
            end else check("rx1_word", 32'(b_rx_data), 32'(q1.pop_front()));
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge m_clk);
    endtask

    task automatic push_tx0(input logic [7:0] d);
        int n = 0;
        while (!a_tx_ready && n < 20) begin cyc(1); n++; end
        check("tx0_ready_wait", 32'(n < 20), 32'd1);
        a_tx_data = d; a_tx_valid = 1'b1;
        cyc(1);
        a_tx_valid = 1'b0;
        check("tx0_ready_low", 32'(a_tx_ready), 32'd0);
    endtask

    task automatic push_tx3(input logic [15:0] d);
        int n = 0;
        while (!b_tx_ready && n < 20) begin cyc(1); n++; end
        check("tx3_ready_wait", 32'(n < 20), 32'd1);
        b_tx_data = d; b_tx_valid = 1'b1;
        cyc(1);
        b_tx_valid = 1'b0;
        check("tx3_ready_low", 32'(b_tx_ready), 32'd0);
    endtask

    // Mode 0: controller samples miso and the peripheral samples mosi on the rising edge
    task automatic xfer0(input logic [7:0] mw, input int nbits, output logic [7:0] sw, output int lat);
        sw = '0; lat = 0;
        for (int i = 0; i < nbits; i++) begin
            a_mosi = mw[7-i];
            cyc(4);
            sw = {sw[6:0], a_miso};
            a_sck = 1'b1;
            for (int k = 1; k <= 4; k++) begin
                cyc(1);
                if (lat == 0 && i == 7 && a_rx_valid) lat = k;
            end
            a_sck = 1'b0;
        end
        cyc(4);
    endtask

    // Mode 3: launch on falling (leading) edge, sample on rising (trailing) edge
    task automatic xfer3(input logic [15:0] mw, output logic [15:0] sw);
        sw = '0;
        for (int i = 0; i < 16; i++) begin
            b_sck = 1'b0;
            b_mosi = mw[15-i];
            cyc(4);
            sw = {sw[14:0], b_miso};
            b_sck = 1'b1;
            cyc(4);
        end
    endtask

    typedef struct {
        logic [7:0] tx;
        logic [7:0] mosi;
        logic [7:0] exp_miso;
        logic [7:0] exp_rx;
    } vec_t;
    vec_t vecs[4];

    initial begin
        logic [7:0]  sw0;
        logic [15:0] sw3;
        int lat, base_ev, base_ov, base_und, base_ev3;

        vecs[0] = '{tx: 8'hA5, mosi: 8'h3C, exp_miso: 8'hA5, exp_rx: 8'h3C};
        vecs[1] = '{tx: 8'h00, mosi: 8'hFF, exp_miso: 8'h00, exp_rx: 8'hFF};
        vecs[2] = '{tx: 8'hFF, mosi: 8'h01, exp_miso: 8'hFF, exp_rx: 8'h01};
        vecs[3] = '{tx: 8'h6B, mosi: 8'h80, exp_miso: 8'h6B, exp_rx: 8'h80};

        cyc(3);
        rst = 1'b0;
        cyc(6);

        // Reset state
        check("rst0_rx_data",  32'(a_rx_data), 32'd0);
        check("rst0_rx_valid", 32'(a_rx_valid), 32'd0);
        check("rst0_tx_ready", 32'(a_tx_ready), 32'd1);
        check("rst0_busy",     32'(a_busy), 32'd0);
        check("rst0_miso",     32'(a_miso), 32'd0);
        check("rst0_pulses",   32'({a_ovr, a_und}), 32'd0);
        check("rst3_rx_data",  32'(b_rx_data), 32'd0);
        check("rst3_tx_ready", 32'(b_tx_ready), 32'd1);
        check("rst3_busy",     32'(b_busy), 32'd0);

        // Mode-0 vector table, one framed word per entry
        for (int v = 0; v < 4; v++) begin
            push_tx0(vecs[v].tx);
            a_csn = 1'b0; cyc(4);
            check("m0_busy", 32'(a_busy), 32'd1);
            q0.push_back(vecs[v].exp_rx);
            xfer0(vecs[v].mosi, 8, sw0, lat);
            a_csn = 1'b1; cyc(8);
            check("m0_miso_word", 32'(sw0), 32'(vecs[v].exp_miso));
            check("m0_rx_latency", 32'(lat), 32'd3);
            check("m0_rx_data", 32'(a_rx_data), 32'(vecs[v].exp_rx));
        end

        // Mode 3, two back-to-back words with both TX words handed over in advance
        base_und = b_und_cnt; base_ev3 = b_rx_events;
        push_tx3(16'h1234);
        b_csn = 1'b0; cyc(4);
        push_tx3(16'hBEEF);
        q1.push_back(16'hCAFE);
        xfer3(16'hCAFE, sw3);
        check("m3_miso_w1", 32'(sw3), 32'h1234);
        q1.push_back(16'h0F0F);
        xfer3(16'h0F0F, sw3);
        check("m3_miso_w2", 32'(sw3), 32'hBEEF);
        cyc(4); b_csn = 1'b1; cyc(8);
        check("m3_rx_events", 32'(b_rx_events - base_ev3), 32'd2);
        check("m3_no_underrun", 32'(b_und_cnt - base_und), 32'd0);

        // Mode 3, word started with nothing loaded
        base_und = b_und_cnt;
        b_csn = 1'b0; cyc(4);
        check("m3_underrun_at_fall", 32'(b_und_cnt - base_und), 32'd1);
        q1.push_back(16'h1357);
        xfer3(16'h1357, sw3);
        check("m3_underrun_miso", 32'(sw3), 32'h0000);
        cyc(4); b_csn = 1'b1; cyc(8);
        check("m3_underrun_once", 32'(b_und_cnt - base_und), 32'd1);

        // Two words with the consumer stalled: overwrite and a single overrun pulse
        base_ov = a_ovr_cnt;
        a_rx_ready = 1'b0;
        a_csn = 1'b0; cyc(4); xfer0(8'h11, 8, sw0, lat); a_csn = 1'b1; cyc(8);
        a_csn = 1'b0; cyc(4); xfer0(8'h22, 8, sw0, lat); a_csn = 1'b1; cyc(8);
        check("ovr_count", 32'(a_ovr_cnt - base_ov), 32'd1);
        check("ovr_rx_data", 32'(a_rx_data), 32'h22);
        check("ovr_rx_valid", 32'(a_rx_valid), 32'd1);
        q0.push_back(8'h22);
        a_rx_ready = 1'b1;
        cyc(3);
        check("ovr_drained", 32'(q0.size()), 32'd0);

        // Partial word aborted by csn, then a full word
        base_ev = a_rx_events; base_ov = a_ovr_cnt;
        a_csn = 1'b0; cyc(4); xfer0(8'hFF, 5, sw0, lat); a_csn = 1'b1; cyc(8);
        check("abort_no_rx", 32'(a_rx_events - base_ev), 32'd0);
        check("abort_no_ovr", 32'(a_ovr_cnt - base_ov), 32'd0);
        q0.push_back(8'h81);
        a_csn = 1'b0; cyc(4); xfer0(8'h81, 8, sw0, lat); a_csn = 1'b1; cyc(8);
        check("abort_full_word", 32'(a_rx_data), 32'h81);
        check("abort_rx_events", 32'(a_rx_events - base_ev), 32'd1);

        // Reset three bits into a word; csn stays low so SCK must be ignored afterwards
        push_tx0(8'h77);
        a_csn = 1'b0; cyc(4); xfer0(8'hF0, 3, sw0, lat);
        rst = 1'b1; cyc(2); rst = 1'b0; cyc(1);
        check("mid_rst_rx_data",  32'(a_rx_data), 32'd0);
        check("mid_rst_rx_valid", 32'(a_rx_valid), 32'd0);
        check("mid_rst_tx_ready", 32'(a_tx_ready), 32'd1);
        check("mid_rst_busy",     32'(a_busy), 32'd0);
        check("mid_rst_miso",     32'(a_miso), 32'd0);
        base_ev = a_rx_events;
        a_mosi = 1'b1;
        for (int i = 0; i < 8; i++) begin
            a_sck = 1'b1; cyc(4); a_sck = 1'b0; cyc(4);
        end
        check("post_rst_busy", 32'(a_busy), 32'd0);
        check("post_rst_ignored", 32'(a_rx_events - base_ev), 32'd0);
        a_csn = 1'b1; cyc(8);
        q0.push_back(8'h5A);
        a_csn = 1'b0; cyc(4); xfer0(8'h5A, 8, sw0, lat); a_csn = 1'b1; cyc(8);
        check("post_rst_word", 32'(a_rx_data), 32'h5A);

        check("sb0_empty", 32'(q0.size()), 32'd0);
        check("sb1_empty", 32'(q1.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/spi_peripheral_sync.md
SPI_PERIPHERAL_SYNC -- requirements
Module: spi_peripheral_sync

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
  WORD_W, 8, bits per SPI word, legal 4..32.
  CPOL, 0, SCK idle level.
  CPHA, 0, 0 = sample on leading edge, 1 = sample on trailing edge.
  SYNC_STAGES, 2, flip-flop stages on each pad input, legal 2..3.
REQ-002 The block SHALL have these ports (name, direction, width, meaning):
  m_clk  in  1  system clock; the only clock in the block.
  rst  in  1  reset, synchronous, active-high.
  sck_pad  in  1  SPI clock, asynchronous to m_clk.
  csn_pad  in  1  chip select, active-low, asynchronous.
  mosi_pad  in  1  controller-to-peripheral data.
  miso_pad  out  1  peripheral-to-controller data; driven 0 while csn is inactive.
  rx_data  out  WORD_W  last received word.
  rx_valid  out  1  rx_data holds an unread word.
  rx_ready  in  1  consumer accepts rx_data.
  tx_data  in  WORD_W  next word to transmit.
  tx_valid  in  1  tx_data is offered.
  tx_ready  out  1  TX holding register is empty.
  busy  out  1  synchronized csn is active.
  rx_overrun  out  1  one-cycle pulse: an unread word was overwritten.
  tx_underrun  out  1  one-cycle pulse: a word started with no TX data loaded.

Function
REQ-003 All logic SHALL run on m_clk; sck_pad, csn_pad and mosi_pad SHALL each pass through SYNC_STAGES flip-flops before use.
REQ-004 Edges SHALL be detected from the synchronized signals with one extra register stage. A leading edge is a transition away from CPOL; a trailing edge is a transition back to CPOL.
REQ-005 The sample edge SHALL be the leading edge when CPHA=0 and the trailing edge when CPHA=1; the launch edge SHALL be the opposite edge.
REQ-006 Data SHALL be MSB-first in both directions.
REQ-007 On each sample edge while busy, the RX shift register SHALL shift left and take the synchronized mosi into bit 0; the bit counter SHALL then increment modulo WORD_W.
REQ-008 When the counter wraps to 0, rx_data SHALL be loaded and rx_valid SHALL be set on the next m_clk cycle.
REQ-009 rx_valid SHALL clear in the cycle after rx_valid and rx_ready are both high.
REQ-010 If a new word completes while rx_valid is high and not being accepted in that cycle, rx_data SHALL be overwritten, rx_valid SHALL stay high and rx_overrun SHALL pulse for one cycle.
REQ-011 The TX holding register SHALL accept tx_data on any cycle with tx_valid and tx_ready both high; tx_ready SHALL be the inverse of the holding-register-full flag.
REQ-012 At word start (synchronized csn falling edge, or counter wrap while busy), the TX shift register SHALL load from the holding register and the holding register SHALL empty.
REQ-013 If the holding register is empty at word start, the shift register SHALL load all-zero and tx_underrun SHALL pulse.
REQ-014 A load and a new tx_valid in the same cycle SHALL result in the new word being held for the next word start.
REQ-015 miso_pad SHALL be the shift register MSB while busy, else 0.
REQ-016 Each launch edge SHALL shift the TX shift register left by one, except the first launch edge of a word when CPHA=1; that edge SHALL leave the MSB in place.
REQ-017 Deasserting csn mid-word SHALL clear the bit counter and discard the partial RX word, with no rx_valid and no rx_overrun. The TX shift register SHALL be discarded; the holding register SHALL keep its contents.
REQ-018 SCK edges while csn is inactive SHALL be ignored.
REQ-019 The supported SCK frequency SHALL be at most m_clk/8.

Reset
REQ-020 While rst is high at a m_clk edge, all registers SHALL be cleared, including synchronizers, which SHALL take csn = 1 and sck = CPOL.
REQ-021 After reset: rx_data=0, rx_valid=0, tx_ready=1, busy=0, miso_pad=0, rx_overrun=0, tx_underrun=0, bit counter=0.
REQ-022 Reset asserted mid-word SHALL abort the word.
REQ-023 After reset is released, the first word SHALL be recognized only after a fresh csn falling edge.

Verification
REQ-024 Mode 0, WORD_W=8: load tx 0xA5, send mosi 0x3C -> miso bits 1,0,1,0,0,1,0,1; rx_data=0x3C; rx_valid rises one cycle after the 8th sample edge.
REQ-025 Mode 3, WORD_W=16: two back-to-back words, tx 0x1234 then 0xBEEF preloaded via handshake -> both appear on miso in order; two rx_valid events; tx_underrun never pulses.
REQ-026 Send 2 words with rx_ready held 0 -> rx_data equals the 2nd word and rx_overrun pulses exactly once.
REQ-027 Start a word with no tx_valid -> miso is all 0 and tx_underrun pulses once at csn fall.
REQ-028 Deassert csn after 5 bits, then send a full word 0x81 -> no rx_valid for the partial word; rx_data=0x81 after the full word.
REQ-029 Assert rst after 3 bits of a word -> all outputs return to their REQ-021 values; SCK edges are ignored until csn toggles.
